// File: rtl/fb_write_merger.sv
// Framebuffer write merger: coalesces consecutive same-address word writes into one 32-bit FIFO write.
// Latency: a held word leaves on the next miss, on flush, or TIMEOUT input-idle cycles after its last write.
// Backpressure: out_full stalls emission; in_ready drops for misses while full, and whenever flush is high.
module fb_write_merger #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_wen,
  input  logic [15:0] in_addr,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_wen,
  output logic [31:0] out_wd,
  input  logic        out_full,
  output logic        idle,
  output logic [15:0] merge_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]    r_state;
  logic [15:0]   r_hold_addr;
  logic [15:0]   r_hold_data;
  logic [TW-1:0] r_timer;
  logic [15:0]   r_merge_cnt;
  logic          r_idle;

  logic w_hold_valid;
  logic w_hit;
  logic w_ready;
  logic w_accept;
  logic w_expired;
  logic w_emit;

  // Hit/accept/emit decode; a hit suppresses a coincident timer expiry,
  // and reset blocks the emit so a held word is dropped, never written.
  always_comb begin
    w_hold_valid = (r_state == S_HOLD);
    w_hit        = w_hold_valid && (in_addr == r_hold_addr);
    w_ready      = !flush && (!w_hold_valid || w_hit || !out_full);
    w_accept     = in_wen && w_ready;
    w_expired    = w_hold_valid && (r_timer == TMAX);
    w_emit       = !rst && w_hold_valid && !out_full &&
                   ((in_wen && !w_hit) || (w_expired && !(w_accept && w_hit)) || flush);
  end

  // State and hold register: a miss loads (emitting the old word if any), a hit overwrites data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_hold_addr <= '0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_state     <= S_HOLD;
      r_hold_addr <= in_addr;
      r_hold_data <= in_data;
    end else if (w_emit) begin
      r_state     <= S_EMPTY;
    end
  end

  // Idle timer: restarts on any accepted write or emit, saturates while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_accept || w_emit) begin
      r_timer <= '0;
    end else if (w_hold_valid && (r_timer != TMAX)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Saturating count of coalesced (hit) writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_merge_cnt <= '0;
    end else if (w_accept && w_hit && (r_merge_cnt != 16'hFFFF)) begin
      r_merge_cnt <= r_merge_cnt + 16'd1;
    end
  end

  // Registered idle flag tracking the next-cycle hold state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= 1'b1;
    end else if (w_accept) begin
      r_idle <= 1'b0;
    end else if (w_emit) begin
      r_idle <= 1'b1;
    end
  end

  assign in_ready  = w_ready;
  assign out_wen   = w_emit;
  assign out_wd    = {r_hold_addr, r_hold_data};
  assign idle      = r_idle;
  assign merge_cnt = r_merge_cnt;

endmodule

// File: tb/tb_fb_write_merger.sv
module tb_fb_write_merger;

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic        in_wen;
  logic [15:0] in_addr;
  logic [15:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        out_wen;
  logic [31:0] out_wd;
  logic        out_full;
  logic        idle;
  logic [15:0] merge_cnt;

  fb_write_merger #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_wen(in_wen), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_wen(out_wen), .out_wd(out_wd),
    .out_full(out_full), .idle(idle), .merge_cnt(merge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        wen;
    logic [15:0] addr;
    logic [15:0] data;
    logic        flush;
    logic        full;
    logic        e_wen;
    logic        chk_wd;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_idle;
    logic [15:0] e_merge;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mk(input logic wen, input logic [15:0] addr, input logic [15:0] data,
                              input logic fl, input logic full, input logic e_wen,
                              input logic chk_wd, input logic [31:0] e_wd, input logic e_rdy,
                              input logic e_idle, input logic [15:0] e_merge);
    vec_t v;
    v.wen = wen; v.addr = addr; v.data = data; v.flush = fl; v.full = full;
    v.e_wen = e_wen; v.chk_wd = chk_wd; v.e_wd = e_wd; v.e_rdy = e_rdy;
    v.e_idle = e_idle; v.e_merge = e_merge;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic fl, input logic full);
    rst = r; in_wen = w; in_addr = a; in_data = d; flush = fl; out_full = full;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    adv();
    rst = 1'b0;
  endtask

  // Behavioural reference: held word plus a count of quiet cycles since its last write.
  logic        m_v;
  logic [15:0] m_a, m_d, m_merge;
  int          m_quiet;
  logic        m_idle;

  logic saw_wen;

  initial begin
    rst = 1'b1; in_wen = 1'b0; in_addr = '0; in_data = '0; flush = 1'b0; out_full = 1'b0;
    @(posedge clk); #1;

    //        wen  addr     data     fl   full e_wen chk e_wd           rdy  idle merge
    tv[0]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 32'h0000_0000, 1, 1, 16'd0);
    tv[1]  = mk(1, 16'h0010, 16'hAAAA, 0, 0, 0, 0, 32'h0,         1, 1, 16'd0);
    tv[2]  = mk(1, 16'h0010, 16'h5555, 0, 0, 0, 0, 32'h0,         1, 0, 16'd0);
    tv[3]  = mk(1, 16'h0011, 16'h1234, 0, 0, 1, 1, 32'h0010_5555, 1, 0, 16'd1);
    tv[4]  = mk(0, 16'h0000, 16'h0000, 0, 1, 0, 0, 32'h0,         0, 0, 16'd1);
    tv[5]  = mk(1, 16'h0040, 16'h0007, 0, 1, 0, 0, 32'h0,         0, 0, 16'd1);
    tv[6]  = mk(1, 16'h0040, 16'h0007, 0, 0, 1, 1, 32'h0011_1234, 1, 0, 16'd1);
    tv[7]  = mk(1, 16'h0040, 16'h0008, 0, 1, 0, 0, 32'h0,         1, 0, 16'd1);
    tv[8]  = mk(0, 16'h0000, 16'h0000, 0, 1, 0, 0, 32'h0,         0, 0, 16'd2);
    tv[9]  = mk(1, 16'h0030, 16'h0001, 0, 0, 1, 1, 32'h0040_0008, 1, 0, 16'd2);
    tv[10] = mk(1, 16'h0030, 16'h0099, 1, 1, 0, 0, 32'h0,         0, 0, 16'd2);
    tv[11] = mk(0, 16'h0000, 16'h0000, 1, 1, 0, 0, 32'h0,         0, 0, 16'd2);
    tv[12] = mk(0, 16'h0000, 16'h0000, 1, 0, 1, 1, 32'h0030_0001, 0, 0, 16'd2);
    tv[13] = mk(0, 16'h0000, 16'h0000, 1, 0, 0, 0, 32'h0,         0, 1, 16'd2);
    tv[14] = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0,         1, 1, 16'd2);

    // Directed table: merge, miss under full, hit under full, flush draining.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, tv[i].wen, tv[i].addr, tv[i].data, tv[i].flush, tv[i].full);
      check($sformatf("vec%0d out_wen", i), 32'(out_wen), 32'(tv[i].e_wen));
      if (tv[i].chk_wd) check($sformatf("vec%0d out_wd", i), out_wd, tv[i].e_wd);
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tv[i].e_rdy));
      check($sformatf("vec%0d idle", i), 32'(idle), 32'(tv[i].e_idle));
      check($sformatf("vec%0d merge_cnt", i), 32'(merge_cnt), 32'(tv[i].e_merge));
      adv();
    end

    // Timeout: emit exactly TIMEOUT cycles after the accept, idle the cycle after.
    do_reset();
    drive(1'b0, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b0);
    adv();
    for (int k = 1; k <= 18; k++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      check($sformatf("tmo k=%0d out_wen", k), 32'(out_wen), (k == TMO) ? 32'd1 : 32'd0);
      if (k == TMO) begin
        check("tmo out_wd", out_wd, 32'h0020_BEEF);
        check("tmo idle at emit", 32'(idle), 32'd0);
      end
      if (k == TMO + 1) check("tmo idle after", 32'(idle), 32'd1);
      adv();
    end

    // Reset while a word is held (and flush requested): the word is dropped, not written.
    do_reset();
    drive(1'b0, 1'b1, 16'h0060, 16'h0001, 1'b0, 1'b0);
    adv();
    drive(1'b0, 1'b1, 16'h0060, 16'h0002, 1'b0, 1'b0);
    adv();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("rst pre merge_cnt", 32'(merge_cnt), 32'd1);
    adv();
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check("rst cycle out_wen", 32'(out_wen), 32'd0);
    adv();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("rst after out_wen", 32'(out_wen), 32'd0);
    check("rst after idle", 32'(idle), 32'd1);
    check("rst after merge_cnt", 32'(merge_cnt), 32'd0);
    check("rst after out_wd", out_wd, 32'd0);
    check("rst after in_ready", 32'(in_ready), 32'd1);
    adv();

    // Randomized traffic against the reference model.
    do_reset();
    m_v = 1'b0; m_a = '0; m_d = '0; m_merge = '0; m_quiet = 0; m_idle = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic r, w, fl, full, hit, rdy, acc, expd, emit;
      logic [15:0] a, d;
      r    = ($urandom_range(0, 199) == 0);
      w    = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 9) == 0);
      full = ($urandom_range(0, 9) < 3);
      a    = 16'h0100 + 16'($urandom_range(0, 3));
      d    = 16'($urandom);
      drive(r, w, a, d, fl, full);
      hit  = m_v && (a == m_a);
      rdy  = !fl && (!m_v || hit || !full);
      acc  = w && rdy;
      expd = m_v && (m_quiet >= TMO - 1);
      emit = !r && m_v && !full && ((acc && !hit) || (expd && !(acc && hit)) || fl);
      check($sformatf("rnd%0d out_wen", c), 32'(out_wen), 32'(emit));
      if (emit) check($sformatf("rnd%0d out_wd", c), out_wd, {m_a, m_d});
      check($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(rdy));
      check($sformatf("rnd%0d idle", c), 32'(idle), 32'(m_idle));
      check($sformatf("rnd%0d merge_cnt", c), 32'(merge_cnt), 32'(m_merge));
      if (r) begin
        m_v = 1'b0; m_a = '0; m_d = '0; m_merge = '0; m_quiet = 0;
      end else if (acc && hit) begin
        m_d = d; m_quiet = 0;
        if (m_merge != 16'hFFFF) m_merge = m_merge + 16'd1;
      end else if (acc) begin
        m_v = 1'b1; m_a = a; m_d = d; m_quiet = 0;
      end else if (emit) begin
        m_v = 1'b0; m_quiet = 0;
      end else if (m_v) begin
        m_quiet++;
      end
      m_idle = !m_v;
      adv();
    end

    // Saturation: 70000 writes to one address give 69999 merges.
    do_reset();
    saw_wen = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      drive(1'b0, 1'b1, 16'h0050, 16'(i), 1'b0, 1'b0);
      if (out_wen) saw_wen = 1'b1;
      adv();
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check("sat merge_cnt", 32'(merge_cnt), 32'h0000_FFFF);
    check("sat no out_wen", 32'(saw_wen), 32'd0);
    check("sat idle", 32'(idle), 32'd0);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
